mouse_cursor: RTL and testbench

Downstream consumer of the PS/2 mouse decoder. Takes its wrapping x/y/z accumulators, button state and one-cycle `update` strobe and converts them into a screen-clamped cursor position. Qualifying changes are queued as 32-bit event words in a small FIFO, which the CPU drains through a memory-mapped read strobe. Glitches from decoder re-initialisation are suppressed through a resync input.

---
 rtl/mouse_cursor.sv | 178 +++++++++++++++++
 tb/tb_mouse_cursor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor.sv
// Converts PS/2 decoder accumulators into a screen-clamped cursor and queues
// change events in a small FIFO drained by CPU read strobes.
module mouse_cursor #(
    parameter int unsigned C_X_BITS     = 11,
    parameter int unsigned C_Y_BITS     = 11,
    parameter int unsigned C_Z_BITS     = 11,
    parameter int unsigned C_W          = 1024,
    parameter int unsigned C_H          = 768,
    parameter int unsigned C_FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            resync,
    input  logic                            in_update,
    input  logic [C_X_BITS-1:0]             in_x,
    input  logic [C_Y_BITS-1:0]             in_y,
    input  logic [C_Z_BITS-1:0]             in_z,
    input  logic [2:0]                      in_btn,
    output logic [C_X_BITS-1:0]             cur_x,
    output logic [C_Y_BITS-1:0]             cur_y,
    output logic [2:0]                      cur_btn,
    input  logic                            rd,
    output logic [31:0]                     rd_data,
    output logic [$clog2(C_FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned XW = C_X_BITS + 2;
    localparam int unsigned YW = C_Y_BITS + 2;

    localparam logic signed [XW-1:0]       X_MAX = XW'(C_W - 1);
    localparam logic signed [YW-1:0]       Y_MAX = YW'(C_H - 1);
    localparam logic signed [C_Z_BITS-1:0] Z_MAX = C_Z_BITS'(7);
    localparam logic signed [C_Z_BITS-1:0] Z_MIN = C_Z_BITS'(-8);

    logic                primed_q, primed_d;
    logic [C_X_BITS-1:0] prev_x_q, prev_x_d;
    logic [C_Y_BITS-1:0] prev_y_q, prev_y_d;
    logic [C_Z_BITS-1:0] prev_z_q, prev_z_d;

    logic                s1_valid_q, s1_valid_d;
    logic [C_X_BITS-1:0] s1_dx_q, s1_dx_d;
    logic [C_Y_BITS-1:0] s1_dy_q, s1_dy_d;
    logic [C_Z_BITS-1:0] s1_dz_q, s1_dz_d;
    logic [2:0]          s1_btn_q, s1_btn_d;

    logic [C_X_BITS-1:0] cur_x_q, cur_x_d;
    logic [C_Y_BITS-1:0] cur_y_q, cur_y_d;
    logic [2:0]          cur_btn_q, cur_btn_d;

    logic                ovf_q, ovf_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [31:0]         mem_q [C_FIFO_DEPTH];

    logic                accept;
    logic signed [XW-1:0] nx_s;
    logic signed [YW-1:0] ny_s;
    logic [C_X_BITS-1:0] nx;
    logic [C_Y_BITS-1:0] ny;
    logic [3:0]          dz_sat;
    logic                push_req, push_ok, pop, full;
    logic [31:0]         push_word;

    // Stage 1: resync discards a coincident update and forces re-priming.
    always_comb begin
        accept     = in_update & ~resync;
        primed_d   = resync ? 1'b0 : (accept ? 1'b1 : primed_q);
        prev_x_d   = accept ? in_x : prev_x_q;
        prev_y_d   = accept ? in_y : prev_y_q;
        prev_z_d   = accept ? in_z : prev_z_q;
        s1_valid_d = accept;
        s1_dx_d    = (accept && primed_q) ? in_x - prev_x_q : '0;
        s1_dy_d    = (accept && primed_q) ? in_y - prev_y_q : '0;
        s1_dz_d    = (accept && primed_q) ? in_z - prev_z_q : '0;
        s1_btn_d   = accept ? in_btn : s1_btn_q;
    end

    // Stage 2: clamp the new position and saturate the wheel delta.
    always_comb begin
        nx_s = $signed({2'b00, cur_x_q}) + $signed({{2{s1_dx_q[C_X_BITS-1]}}, s1_dx_q});
        ny_s = $signed({2'b00, cur_y_q}) + $signed({{2{s1_dy_q[C_Y_BITS-1]}}, s1_dy_q});

        if (nx_s[XW-1])      nx = '0;
        else if (nx_s > X_MAX) nx = C_X_BITS'(C_W - 1);
        else                 nx = nx_s[C_X_BITS-1:0];

        if (ny_s[YW-1])      ny = '0;
        else if (ny_s > Y_MAX) ny = C_Y_BITS'(C_H - 1);
        else                 ny = ny_s[C_Y_BITS-1:0];

        if ($signed(s1_dz_q) > Z_MAX)      dz_sat = 4'b0111;
        else if ($signed(s1_dz_q) < Z_MIN) dz_sat = 4'b1000;
        else                               dz_sat = s1_dz_q[3:0];

        push_req = s1_valid_q && ((nx != cur_x_q) || (ny != cur_y_q) ||
                                  (s1_btn_q != cur_btn_q) || (dz_sat != 4'd0));
        pop      = rd && (count_q != '0);
        full     = (count_q == CW'(C_FIFO_DEPTH));
        push_ok  = push_req && (!full || pop);
        push_word = {1'b1, ovf_q, s1_btn_q, dz_sat, 11'(ny), 1'b0, 11'(nx)};

        cur_x_d   = s1_valid_q ? nx : cur_x_q;
        cur_y_d   = s1_valid_q ? ny : cur_y_q;
        cur_btn_d = s1_valid_q ? s1_btn_q : cur_btn_q;
    end

    // FIFO bookkeeping; a dropped push leaves a sticky overflow for the next accepted word.
    always_comb begin
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            ovf_d    = 1'b0;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (push_req) begin
            ovf_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed_q   <= 1'b0;
            prev_x_q   <= '0;
            prev_y_q   <= '0;
            prev_z_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_dz_q    <= '0;
            s1_btn_q   <= '0;
            cur_x_q    <= C_X_BITS'(C_W / 2);
            cur_y_q    <= C_Y_BITS'(C_H / 2);
            cur_btn_q  <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            primed_q   <= primed_d;
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
            prev_z_q   <= prev_z_d;
            s1_valid_q <= s1_valid_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_dz_q    <= s1_dz_d;
            s1_btn_q   <= s1_btn_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cur_btn_q  <= cur_btn_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_word;
    end

    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign cur_btn    = cur_btn_q;
    assign fifo_count = count_q;
    assign rd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_mouse_cursor.sv
// Scoreboard bench for mouse_cursor: a behavioural cursor/FIFO model queues
// expected event words as updates are driven; reads pop and compare them.
module tb_mouse_cursor;

    localparam int W     = 1024;
    localparam int H     = 768;
    localparam int DEPTH = 8;

    logic        clk, reset_n, resync, in_update, rd;
    logic [10:0] in_x, in_y, in_z, cur_x, cur_y;
    logic [2:0]  in_btn, cur_btn;
    logic [31:0] rd_data;
    logic [3:0]  fifo_count;

    mouse_cursor dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .resync     (resync),
        .in_update  (in_update),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_z       (in_z),
        .in_btn     (in_btn),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .cur_btn    (cur_btn),
        .rd         (rd),
        .rd_data    (rd_data),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_primed, m_ovf;
    int          m_px, m_py, m_pz, m_cx, m_cy, m_btn;
    logic [31:0] exp_q[$];
    // Stimulus accumulators
    int          sx, sy, sz, sb;
    int          saved_x, saved_y;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic int wrap_s(input int d);
        int v;
        v = d & 2047;
        if (v >= 1024) v = v - 2048;
        return v;
    endfunction

    task automatic model_update(input int x, input int y, input int z, input int b);
        int dx, dy, dz, nx, ny, dzs;
        bit push;
        logic [31:0] w;
        if (!m_primed) begin
            dx = 0; dy = 0; dz = 0;
            m_primed = 1'b1;
        end else begin
            dx = wrap_s(x - m_px);
            dy = wrap_s(y - m_py);
            dz = wrap_s(z - m_pz);
        end
        m_px = x; m_py = y; m_pz = z;
        nx = m_cx + dx;
        if (nx < 0) nx = 0;
        if (nx > W - 1) nx = W - 1;
        ny = m_cy + dy;
        if (ny < 0) ny = 0;
        if (ny > H - 1) ny = H - 1;
        dzs = (dz > 7) ? 7 : ((dz < -8) ? -8 : dz);
        push = (nx != m_cx) || (ny != m_cy) || (b != m_btn) || (dzs != 0);
        m_cx = nx; m_cy = ny; m_btn = b;
        if (push) begin
            if (exp_q.size() < DEPTH) begin
                w = {1'b1, m_ovf, 3'(b), 4'(dzs), 11'(ny), 1'b0, 11'(nx)};
                exp_q.push_back(w);
                m_ovf = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_update(input int x, input int y, input int z, input int b);
        @(negedge clk);
        in_update = 1'b1;
        in_x = 11'(x); in_y = 11'(y); in_z = 11'(z); in_btn = 3'(b);
        model_update(x, y, z, b);
    endtask

    task automatic move(input int dx, input int dy, input int dz, input int b);
        sx = (sx + dx) & 2047;
        sy = (sy + dy) & 2047;
        sz = (sz + dz) & 2047;
        sb = b;
        do_update(sx, sy, sz, sb);
    endtask

    // Lets the last driven update reach the cursor and FIFO.
    task automatic idle();
        @(negedge clk);
        in_update = 1'b0;
        resync = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_resync();
        @(negedge clk);
        in_update = 1'b0;
        resync = 1'b1;
        m_primed = 1'b0;
        @(negedge clk);
        resync = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        @(negedge clk);
        if (exp_q.size() == 0) check_eq(tag, rd_data, 32'd0);
        else                   check_eq(tag, rd_data, exp_q.pop_front());
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        @(negedge clk);
        check_eq({tag, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; resync = 1'b0; in_update = 1'b0; rd = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; in_btn = '0;
        m_primed = 1'b0; m_ovf = 1'b0;
        m_cx = W / 2; m_cy = H / 2; m_btn = 0;
        m_px = 0; m_py = 0; m_pz = 0;
        sx = 0; sy = 0; sz = 0; sb = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_cur_x", 32'(cur_x), 32'd512);
        check_eq("rst_cur_y", 32'(cur_y), 32'd384);
        check_eq("rst_btn", 32'(cur_btn), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);

        // Priming update produces no motion and no event
        sx = 5; sy = 9;
        do_update(sx, sy, sz, 0);
        idle();
        check_eq("prime_cur_x", 32'(cur_x), 32'd512);
        check_eq("prime_cur_y", 32'(cur_y), 32'd384);
        check_eq("prime_count", 32'(fifo_count), 32'd0);

        // Motion across the accumulator wrap
        do_resync();
        sx = 2045;
        do_update(sx, sy, sz, 0);
        sx = 3; sy = 4;
        do_update(sx, sy, sz, 0);
        idle();
        check_eq("wrap_cur_x", 32'(cur_x), 32'd518);
        check_eq("wrap_cur_y", 32'(cur_y), 32'd379);
        check_eq("wrap_count", 32'(fifo_count), 32'd1);
        check_eq("wrap_ev_x", 32'(rd_data[10:0]), 32'd518);
        check_eq("wrap_ev_y", 32'(rd_data[22:12]), 32'd379);
        drain("wrap_ev");

        // Clamping at both edges
        move(600, 0, 0, 0);
        idle();
        check_eq("clamp_hi", 32'(cur_x), 32'd1023);
        move(-1023, 0, 0, 0);
        move(-1023, 0, 0, 0);
        idle();
        check_eq("clamp_lo", 32'(cur_x), 32'd0);
        check_eq("clamp_count", 32'(fifo_count), 32'd2);
        drain("clamp_ev");

        // Wheel saturation and button-only change
        move(0, 0, 12, 0);
        idle();
        check_eq("wheel_dz", 32'(rd_data[26:23]), 32'h7);
        pop_check("wheel_ev");
        move(0, 0, 0, 4);
        idle();
        check_eq("btn_field", 32'(rd_data[29:27]), 32'd4);
        check_eq("btn_dz", 32'(rd_data[26:23]), 32'd0);
        check_eq("btn_cur", 32'(cur_btn), 32'd4);
        pop_check("btn_ev");

        // FIFO overflow: ten back-to-back events, two dropped
        for (int i = 0; i < 10; i++) move(1, 0, 0, 4);
        idle();
        check_eq("full_count", 32'(fifo_count), 32'd8);
        check_eq("full_cur_x", 32'(cur_x), 32'd10);
        pop_check("ovf_head");
        move(1, 0, 0, 4);
        idle();
        check_eq("ovf_count", 32'(fifo_count), 32'd8);
        pop_check("ovf_pop2");
        move(1, 0, 0, 4);
        idle();
        check_eq("ovf_tail_bit", 32'(rd_data[30]), 32'd0);
        drain("ovf_ev");
        pop_check("empty_rd");
        check_eq("empty_count", 32'(fifo_count), 32'd0);

        // Full FIFO with a pop and a push on the same edge
        for (int i = 0; i < DEPTH; i++) move(1, 0, 0, 4);
        idle();
        check_eq("sim_pre_count", 32'(fifo_count), 32'd8);
        @(negedge clk);
        sx = (sx + 1) & 2047;
        in_update = 1'b1;
        in_x = 11'(sx); in_y = 11'(sy); in_z = 11'(sz); in_btn = 3'(sb);
        @(negedge clk);
        in_update = 1'b0;
        check_eq("sim_head", rd_data, exp_q.pop_front());
        rd = 1'b1;
        model_update(sx, sy, sz, sb);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        check_eq("sim_count", 32'(fifo_count), 32'd8);
        drain("sim_ev");

        // Resync coincident with an update, then a re-priming update
        saved_x = m_cx; saved_y = m_cy;
        @(negedge clk);
        resync = 1'b1; in_update = 1'b1;
        in_x = 11'd500; in_y = 11'(sy); in_z = 11'(sz); in_btn = 3'(sb);
        m_primed = 1'b0;
        @(negedge clk);
        resync = 1'b0; in_update = 1'b0;
        sx = 0;
        do_update(sx, sy, sz, sb);
        idle();
        check_eq("resync_cur_x", 32'(cur_x), 32'(saved_x));
        check_eq("resync_cur_y", 32'(cur_y), 32'(saved_y));
        check_eq("resync_count", 32'(fifo_count), 32'd0);
        move(5, 0, 0, sb);
        idle();
        check_eq("post_resync_x", 32'(cur_x), 32'(saved_x + 5));
        drain("post_resync_ev");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
